// File: rtl/odin_sched_pkg.sv
// Shared types and default widths for the tinyODIN inference scheduler.
// The FSM state encoding is fixed so waveforms decode the same everywhere.
package odin_sched_pkg;

   localparam int TICK_W_DEF = 8;
   localparam int WDOG_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      ADVANCE = 3'd3,
      FINISH  = 3'd4
   } state_e;

endpackage

// File: rtl/odin_done_tracker.sv
// Tracks per-tick completion of spikecore and ODIN with two sticky flags.
// all_done also counts a done seen in the current cycle so no extra wait is added.
module odin_done_tracker (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   input  logic sc_done,
   input  logic odin_done,
   output logic all_done
);

   logic sc_seen_r;
   logic odin_seen_r;
   logic sc_now_s;
   logic odin_now_s;

   // Sticky seen-flags; clear wins over a done in the same cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sc_seen_r   <= 1'b0;
         odin_seen_r <= 1'b0;
      end else if (clr) begin
         sc_seen_r   <= 1'b0;
         odin_seen_r <= 1'b0;
      end else if (en) begin
         if (sc_done) begin
            sc_seen_r <= 1'b1;
         end
         if (odin_done) begin
            odin_seen_r <= 1'b1;
         end
      end
   end

   assign sc_now_s   = sc_seen_r   | (en & sc_done);
   assign odin_now_s = odin_seen_r | (en & odin_done);
   assign all_done   = sc_now_s & odin_now_s;

endmodule

// File: rtl/odin_inference_scheduler.sv
// Sequences one tinyODIN inference as num_ticks timesteps with a per-tick watchdog.
// Outputs are registered from the next state, so they behave as a Moore decode.
module odin_inference_scheduler
   import odin_sched_pkg::*;
#(
   parameter int                TICK_W     = TICK_W_DEF,
   parameter int                WDOG_W     = WDOG_W_DEF,
   parameter logic [WDOG_W-1:0] WDOG_LIMIT = {WDOG_W{1'b1}}
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [TICK_W-1:0] num_ticks_i,
   input  logic              spikecore_done_i,
   input  logic              odin_done_i,
   output logic              tick_start_o,
   output logic [TICK_W-1:0] tick_o,
   output logic              busy_o,
   output logic              inference_done_o,
   output logic              timeout_o
);

   localparam logic [TICK_W-1:0] TICK_ONE_C  = {{(TICK_W-1){1'b0}}, 1'b1};
   localparam logic [TICK_W-1:0] TICK_ZERO_C = {TICK_W{1'b0}};
   localparam logic [WDOG_W-1:0] WDOG_ONE_C  = {{(WDOG_W-1){1'b0}}, 1'b1};
   localparam logic [WDOG_W-1:0] WDOG_ZERO_C = {WDOG_W{1'b0}};
   localparam logic [WDOG_W-1:0] WDOG_MAX_C  = {WDOG_W{1'b1}};
   localparam logic [WDOG_W-1:0] WDOG_LAST_C = WDOG_LIMIT - WDOG_ONE_C;
   localparam logic              WDOG_EN_C   = (WDOG_LIMIT != WDOG_ZERO_C);

   state_e              state_r;
   state_e              state_s;
   state_e              fsm_next_s;
   logic [TICK_W-1:0]   tick_r;
   logic [TICK_W-1:0]   tick_next_s;
   logic [TICK_W-1:0]   num_ticks_r;
   logic [WDOG_W-1:0]   wdog_r;
   logic                timeout_r;
   logic                tick_start_r;
   logic                busy_r;
   logic                done_r;

   logic                abort_s;
   logic                latch_s;
   logic                tick_inc_s;
   logic                timeout_set_s;
   logic                wdog_clr_s;
   logic                wdog_inc_s;
   logic                seen_clr_s;
   logic                seen_en_s;
   logic                all_done_s;

   odin_done_tracker u_done_tracker (
      .CLK       (CLK),
      .RST       (RST),
      .clr       (seen_clr_s),
      .en        (seen_en_s),
      .sc_done   (spikecore_done_i),
      .odin_done (odin_done_i),
      .all_done  (all_done_s)
   );

   assign tick_next_s = tick_r + TICK_ONE_C;
   assign abort_s     = abort_i & (state_r != IDLE);

   // Next-state and datapath strobes; abort overrides every transition below.
   always_comb begin
      fsm_next_s    = state_r;
      latch_s       = 1'b0;
      tick_inc_s    = 1'b0;
      timeout_set_s = 1'b0;
      wdog_clr_s    = 1'b0;
      wdog_inc_s    = 1'b0;
      seen_clr_s    = 1'b0;
      seen_en_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               latch_s = 1'b1;
               if (num_ticks_i == TICK_ZERO_C) begin
                  fsm_next_s = FINISH;
               end else begin
                  fsm_next_s = ISSUE;
               end
            end else begin
               fsm_next_s = IDLE;
            end
         end
         ISSUE: begin
            seen_clr_s = 1'b1;
            wdog_clr_s = 1'b1;
            fsm_next_s = WAIT;
         end
         WAIT: begin
            seen_en_s  = 1'b1;
            wdog_inc_s = 1'b1;
            if (all_done_s) begin
               fsm_next_s = ADVANCE;
            end else if (WDOG_EN_C && (wdog_r == WDOG_LAST_C)) begin
               fsm_next_s    = FINISH;
               timeout_set_s = 1'b1;
            end else begin
               fsm_next_s = WAIT;
            end
         end
         ADVANCE: begin
            tick_inc_s = 1'b1;
            if (tick_next_s == num_ticks_r) begin
               fsm_next_s = FINISH;
            end else begin
               fsm_next_s = ISSUE;
            end
         end
         FINISH: begin
            fsm_next_s = IDLE;
         end
         default: begin
            fsm_next_s = IDLE;
         end
      endcase
      if (abort_s) begin
         state_s = IDLE;
      end else begin
         state_s = fsm_next_s;
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Tick counter, latched tick count and sticky timeout flag.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tick_r      <= TICK_ZERO_C;
         num_ticks_r <= TICK_ZERO_C;
         timeout_r   <= 1'b0;
      end else begin
         if (abort_s || latch_s) begin
            tick_r <= TICK_ZERO_C;
         end else if (tick_inc_s) begin
            tick_r <= tick_next_s;
         end
         if (latch_s) begin
            num_ticks_r <= num_ticks_i;
         end
         if (latch_s) begin
            timeout_r <= 1'b0;
         end else if (timeout_set_s && !abort_s) begin
            timeout_r <= 1'b1;
         end
      end
   end

   // Per-tick watchdog; saturates instead of wrapping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wdog_r <= WDOG_ZERO_C;
      end else if (wdog_clr_s) begin
         wdog_r <= WDOG_ZERO_C;
      end else if (wdog_inc_s && (wdog_r != WDOG_MAX_C)) begin
         wdog_r <= wdog_r + WDOG_ONE_C;
      end
   end

   // Output flops decoded from the state being entered.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tick_start_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         tick_start_r <= (state_s == ISSUE);
         busy_r       <= (state_s != IDLE);
         done_r       <= (state_s == FINISH);
      end
   end

   assign tick_start_o     = tick_start_r;
   assign tick_o           = tick_r;
   assign busy_o           = busy_r;
   assign inference_done_o = done_r;
   assign timeout_o        = timeout_r;

endmodule

// File: tb/tb_odin_inference_scheduler.sv
// Directed bench for odin_inference_scheduler: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences (watchdog, abort, reset, 255 ticks).
module tb_odin_inference_scheduler;

   logic       CLK;
   logic       RST;
   logic       start_i;
   logic       abort_i;
   logic [7:0] num_ticks_i;
   logic       spikecore_done_i;
   logic       odin_done_i;
   logic       tick_start_o;
   logic [7:0] tick_o;
   logic       busy_o;
   logic       inference_done_o;
   logic       timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   odin_inference_scheduler #(
      .TICK_W     (8),
      .WDOG_W     (16),
      .WDOG_LIMIT (16'd8)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .num_ticks_i      (num_ticks_i),
      .spikecore_done_i (spikecore_done_i),
      .odin_done_i      (odin_done_i),
      .tick_start_o     (tick_start_o),
      .tick_o           (tick_o),
      .busy_o           (busy_o),
      .inference_done_o (inference_done_o),
      .timeout_o        (timeout_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       start;
      logic       abort;
      logic [7:0] nt;
      logic       sc;
      logic       od;
      logic       e_ts;
      logic [7:0] e_tick;
      logic       e_busy;
      logic       e_done;
      logic       e_to;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      start_i          = 1'b0;
      abort_i          = 1'b0;
      num_ticks_i      = 8'd0;
      spikecore_done_i = 1'b0;
      odin_done_i      = 1'b0;
   endtask

   // Runs one inference; dones are driven od_at/sc_at cycles after each tick_start (-1 = never).
   task automatic run_inf(input int nt, input int od_at, input int sc_at, input int abort_tick,
                          input int exp_gap, input int budget,
                          output int ts_cnt, output int done_cnt, output int tick_at_done,
                          output int to_at_done, output int done_since);
      int  since;
      bit  fin;
      ts_cnt       = 0;
      done_cnt     = 0;
      tick_at_done = -1;
      to_at_done   = -1;
      done_since   = -1;
      since        = 0;
      fin          = 1'b0;
      idle_inputs();
      start_i     = 1'b1;
      num_ticks_i = nt[7:0];
      step();
      start_i     = 1'b0;
      num_ticks_i = ~nt[7:0];
      check("timeout cleared on start", timeout_o, 0);
      check("first tick_start latency", tick_start_o, 1);
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (tick_start_o) begin
            if (ts_cnt > 0 && exp_gap > 0) check("tick_start spacing", since + 1, exp_gap);
            check("tick index at tick_start", tick_o, ts_cnt);
            ts_cnt++;
            since = 0;
         end else begin
            since++;
         end
         if (inference_done_o) begin
            done_cnt++;
            tick_at_done = tick_o;
            to_at_done   = timeout_o;
            done_since   = since;
            fin          = 1'b1;
         end else if (!busy_o) begin
            fin = 1'b1;
         end
         if (fin) break;
         abort_i          = (abort_tick >= 0) && (ts_cnt == abort_tick + 1) && (since == 1);
         start_i          = (ts_cnt == 2) && (since == 2);
         odin_done_i      = (since == od_at) && !abort_i;
         spikecore_done_i = (since == sc_at) && !abort_i;
         step();
      end
      check("inference ended within budget", fin, 1);
      idle_inputs();
      step();
      check("busy low after inference", busy_o, 0);
      check("done is a single pulse", inference_done_o, 0);
   endtask

   int ts_cnt, done_cnt, tick_at_done, to_at_done, done_since;

   initial begin
      // start, abort, nt, sc, od | ts, tick, busy, done, to
      vecs[0]  = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

      idle_inputs();
      RST = 1'b1;
      step();
      step();
      check("reset tick_start", tick_start_o, 0);
      check("reset tick", tick_o, 0);
      check("reset busy", busy_o, 0);
      check("reset done", inference_done_o, 0);
      check("reset timeout", timeout_o, 0);
      RST = 1'b0;
      step();

      for (int i = 0; i < 13; i++) begin
         start_i          = vecs[i].start;
         abort_i          = vecs[i].abort;
         num_ticks_i      = vecs[i].nt;
         spikecore_done_i = vecs[i].sc;
         odin_done_i      = vecs[i].od;
         step();
         check($sformatf("vec%0d tick_start", i), tick_start_o, vecs[i].e_ts);
         check($sformatf("vec%0d tick", i), tick_o, vecs[i].e_tick);
         check($sformatf("vec%0d busy", i), busy_o, vecs[i].e_busy);
         check($sformatf("vec%0d done", i), inference_done_o, vecs[i].e_done);
         check($sformatf("vec%0d timeout", i), timeout_o, vecs[i].e_to);
      end
      idle_inputs();
      step();

      // Three ticks, both dones 5 cycles after each tick_start.
      run_inf(3, 5, 5, -1, 7, 200, ts_cnt, done_cnt, tick_at_done, to_at_done, done_since);
      check("nt3 tick_start count", ts_cnt, 3);
      check("nt3 done count", done_cnt, 1);
      check("nt3 tick at done", tick_at_done, 3);
      check("nt3 done latency", done_since, 7);
      check("nt3 timeout", to_at_done, 0);

      // Opposite order: odin first, spikecore later.
      run_inf(2, 2, 7, -1, 9, 200, ts_cnt, done_cnt, tick_at_done, to_at_done, done_since);
      check("order tick_start count", ts_cnt, 2);
      check("order done count", done_cnt, 1);
      check("order tick at done", tick_at_done, 2);
      check("order done latency", done_since, 9);

      // Spikecore never finishes: watchdog ends the inference after 8 WAIT cycles.
      run_inf(1, 1, -1, -1, 0, 200, ts_cnt, done_cnt, tick_at_done, to_at_done, done_since);
      check("wdog done count", done_cnt, 1);
      check("wdog done latency", done_since, 9);
      check("wdog timeout at done", to_at_done, 1);
      step();
      step();
      check("timeout sticky in idle", timeout_o, 1);

      // Dones land in the last watchdog cycle: advance wins, no timeout.
      run_inf(1, 8, 8, -1, 0, 200, ts_cnt, done_cnt, tick_at_done, to_at_done, done_since);
      check("wdog edge done count", done_cnt, 1);
      check("wdog edge done latency", done_since, 10);
      check("wdog edge timeout", to_at_done, 0);
      check("wdog edge tick at done", tick_at_done, 1);

      // Abort in WAIT of tick 2; a start pulse mid-run is ignored.
      run_inf(4, 3, 3, 2, 5, 200, ts_cnt, done_cnt, tick_at_done, to_at_done, done_since);
      check("abort tick_start count", ts_cnt, 3);
      check("abort no done pulse", done_cnt, 0);
      check("abort tick cleared", tick_o, 0);
      check("abort timeout unchanged", timeout_o, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("abort stays idle", busy_o | inference_done_o | tick_start_o, 0);
      end

      // Asynchronous reset in WAIT of tick 1.
      start_i     = 1'b1;
      num_ticks_i = 8'd3;
      step();
      idle_inputs();
      step();
      spikecore_done_i = 1'b1;
      odin_done_i      = 1'b1;
      step();
      idle_inputs();
      step();
      step();
      check("pre-reset tick", tick_o, 1);
      check("pre-reset busy", busy_o, 1);
      #2;
      RST = 1'b1;
      #1;
      check("async reset tick", tick_o, 0);
      check("async reset busy", busy_o, 0);
      check("async reset flags", tick_start_o | inference_done_o | timeout_o, 0);
      step();
      #3;
      RST = 1'b0;
      step();
      check("after reset idle", busy_o, 0);

      // Maximum tick count.
      run_inf(255, 1, 1, -1, 3, 1000, ts_cnt, done_cnt, tick_at_done, to_at_done, done_since);
      check("nt255 tick_start count", ts_cnt, 255);
      check("nt255 done count", done_cnt, 1);
      check("nt255 tick at done", tick_at_done, 255);
      check("nt255 done latency", done_since, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
